// File: rtl/rvvi_ack_receiver.sv
// -----------------------------------------------------------------------------
// rvvi_ack_receiver
//
// Consumes the 9-word acknowledgement frames that the host returns for each
// RVVI trace frame (Ethernet MAC RX AXI-stream side). It extracts the echoed
// frame count, Minstret and host-load word, keeps the number of
// unacknowledged trace frames, counts lost and bad replies, and raises
// ExternalStall when the host falls too far behind.
//
// Ports:
//   clk, reset_n        core clock, asynchronous active-low reset
//   RxTdata/Tkeep/Tvalid/Tlast/Tready   AXI-stream RX (byte 0 in [7:0])
//   SentFrame           one-cycle pulse per trace frame sent by the tracer
//   ExternalStall       registered, high while Outstanding >= MAX_OUTSTANDING
//   AckValid            one-cycle pulse when a good reply commits
//   AckFrameCount/AckMinstret/HostLoad   fields of the last good reply
//   Outstanding         unacknowledged trace frames (saturating at 8'hFF)
//   LostFrames          skipped sequence numbers (saturating)
//   BadFrames           malformed or stale replies (saturating)
//
// Optional feature macro: RVVI_ACK_MAC_FILTER_EN
//   Defined  : the destination MAC (w0/w1) must equal LOCAL_MAC; frames to
//              any other MAC are dropped silently.
//   Undefined: the MAC is ignored and LOCAL_MAC is unused.
// -----------------------------------------------------------------------------
module rvvi_ack_receiver #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter logic [15:0] ETH_TYPE        = 16'h005C,
    parameter logic [47:0] LOCAL_MAC       = 48'h0000_0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] RxTdata,
    input  logic [3:0]  RxTkeep,
    input  logic        RxTvalid,
    input  logic        RxTlast,
    output logic        RxTready,
    input  logic        SentFrame,
    output logic        ExternalStall,
    output logic        AckValid,
    output logic [63:0] AckFrameCount,
    output logic [63:0] AckMinstret,
    output logic [31:0] HostLoad,
    output logic [7:0]  Outstanding,
    output logic [15:0] LostFrames,
    output logic [15:0] BadFrames
);

    // state   | meaning
    // IDLE    | waiting for the first beat (w0) of a reply
    // RECV    | capturing w1..w8, checking keep and ethertype
    // DRAIN   | discarding the tail of an over-long reply
    // COMMIT  | one cycle, RX stalled; sequence check and counter update
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_COMMIT} state_e;

    localparam logic [7:0] MaxOut = MAX_OUTSTANDING[7:0];

    state_e      state_q, state_d;
    logic [3:0]  beat_q, beat_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;
    logic [31:0] cnt_lo_q, cnt_lo_d, cnt_hi_q, cnt_hi_d;
    logic [31:0] mi_lo_q, mi_lo_d, mi_hi_q, mi_hi_d;
    logic [31:0] load_cap_q, load_cap_d;
    logic [63:0] exp_seq_q, exp_seq_d;

    logic        ready_q, ready_d;
    logic        ack_valid_q, ack_valid_d;
    logic [63:0] ack_fc_q, ack_fc_d, ack_mi_q, ack_mi_d;
    logic [31:0] host_load_q, host_load_d;
    logic [7:0]  out_q, out_d;
    logic [15:0] lost_q, lost_d, bad_q, bad_d;
    logic        stall_q, stall_d;

    logic        beat_acc, keep_bad, mac_miss, frame_bad, err_now, drop_now;
    logic [63:0] seq_c, seq_diff;
    logic        seq_ge;
    logic [64:0] dec, lost_sum, out_rem;
    logic [8:0]  out_sum;

    assign beat_acc = RxTvalid & ready_q;
    assign keep_bad = (RxTkeep != 4'hF);

`ifdef RVVI_ACK_MAC_FILTER_EN
    assign mac_miss = ((state_q == S_IDLE) && (RxTdata != LOCAL_MAC[31:0])) ||
                      ((state_q == S_RECV) && (beat_q == 4'd1) &&
                       (RxTdata[15:0] != LOCAL_MAC[47:32]));
`else
    logic unused_local_mac;
    assign mac_miss         = 1'b0;
    assign unused_local_mac = ^LOCAL_MAC;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            cnt_lo_q    <= '0;
            cnt_hi_q    <= '0;
            mi_lo_q     <= '0;
            mi_hi_q     <= '0;
            load_cap_q  <= '0;
            exp_seq_q   <= '0;
            ready_q     <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_fc_q    <= '0;
            ack_mi_q    <= '0;
            host_load_q <= '0;
            out_q       <= '0;
            lost_q      <= '0;
            bad_q       <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            cnt_lo_q    <= cnt_lo_d;
            cnt_hi_q    <= cnt_hi_d;
            mi_lo_q     <= mi_lo_d;
            mi_hi_q     <= mi_hi_d;
            load_cap_q  <= load_cap_d;
            exp_seq_q   <= exp_seq_d;
            ready_q     <= ready_d;
            ack_valid_q <= ack_valid_d;
            ack_fc_q    <= ack_fc_d;
            ack_mi_q    <= ack_mi_d;
            host_load_q <= host_load_d;
            out_q       <= out_d;
            lost_q      <= lost_d;
            bad_q       <= bad_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        err_d      = err_q;
        drop_d     = drop_q;
        cnt_lo_d   = cnt_lo_q;
        cnt_hi_d   = cnt_hi_q;
        mi_lo_d    = mi_lo_q;
        mi_hi_d    = mi_hi_q;
        load_cap_d = load_cap_q;
        frame_bad  = 1'b0;
        err_now    = err_q;
        drop_now   = drop_q;
        case (state_q)
            S_IDLE: begin
                if (beat_acc) begin
                    // A single-beat frame is short; MAC misses stay silent.
                    if (RxTlast) begin
                        frame_bad = ~mac_miss;
                    end else begin
                        state_d = S_RECV;
                        beat_d  = 4'd1;
                        err_d   = keep_bad;
                        drop_d  = mac_miss;
                    end
                end
            end
            S_RECV: begin
                if (beat_acc) begin
                    err_now  = err_q | keep_bad |
                               ((beat_q == 4'd3) && (RxTdata[15:0] != ETH_TYPE));
                    drop_now = drop_q | mac_miss;
                    err_d    = err_now;
                    drop_d   = drop_now;
                    beat_d   = beat_q + 4'd1;
                    case (beat_q)
                        4'd4:    cnt_lo_d   = RxTdata;
                        4'd5:    cnt_hi_d   = RxTdata;
                        4'd6:    mi_lo_d    = RxTdata;
                        4'd7:    mi_hi_d    = RxTdata;
                        4'd8:    load_cap_d = RxTdata;
                        default: ;
                    endcase
                    if (beat_q == 4'd8) begin
                        if (!RxTlast) begin
                            state_d = S_DRAIN;
                        end else if (err_now || drop_now) begin
                            state_d   = S_IDLE;
                            frame_bad = ~drop_now;
                        end else begin
                            state_d = S_COMMIT;
                        end
                    end else if (RxTlast) begin
                        state_d   = S_IDLE;
                        frame_bad = ~drop_now;
                    end
                end
            end
            S_DRAIN: begin
                if (beat_acc && RxTlast) begin
                    state_d   = S_IDLE;
                    frame_bad = ~drop_q;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        seq_c       = {cnt_hi_q, cnt_lo_q};
        seq_ge      = (seq_c >= exp_seq_q);
        seq_diff    = seq_c - exp_seq_q;
        dec         = '0;
        lost_sum    = {49'b0, lost_q} + {1'b0, seq_diff};
        ack_valid_d = 1'b0;
        ack_fc_d    = ack_fc_q;
        ack_mi_d    = ack_mi_q;
        host_load_d = host_load_q;
        exp_seq_d   = exp_seq_q;
        lost_d      = lost_q;
        bad_d       = bad_q;
        ready_d     = (state_d != S_COMMIT);
        stall_d     = (out_q >= MaxOut);

        if (state_q == S_COMMIT) begin
            if (seq_ge) begin
                ack_valid_d = 1'b1;
                ack_fc_d    = seq_c;
                ack_mi_d    = {mi_hi_q, mi_lo_q};
                host_load_d = load_cap_q;
                exp_seq_d   = seq_c + 64'd1;
                // Skipped sequence numbers also retire their trace frames.
                dec         = {1'b0, seq_diff} + 65'd1;
                lost_d      = (lost_sum > 65'h0FFFF) ? 16'hFFFF : lost_sum[15:0];
            end else if (bad_q != 16'hFFFF) begin
                bad_d = bad_q + 16'd1;
            end
        end else if (frame_bad && (bad_q != 16'hFFFF)) begin
            bad_d = bad_q + 16'd1;
        end

        // Increment and decrement are merged, then floored at 0 and capped.
        out_sum = {1'b0, out_q} + {8'b0, SentFrame};
        out_rem = {56'b0, out_sum} - dec;
        if (dec >= {56'b0, out_sum}) begin
            out_d = 8'h00;
        end else if (out_rem > 65'd255) begin
            out_d = 8'hFF;
        end else begin
            out_d = out_rem[7:0];
        end
    end

    assign RxTready      = ready_q;
    assign ExternalStall = stall_q;
    assign AckValid      = ack_valid_q;
    assign AckFrameCount = ack_fc_q;
    assign AckMinstret   = ack_mi_q;
    assign HostLoad      = host_load_q;
    assign Outstanding   = out_q;
    assign LostFrames    = lost_q;
    assign BadFrames     = bad_q;

endmodule

// File: tb/tb_rvvi_ack_receiver.sv
module tb_rvvi_ack_receiver;

    localparam logic [15:0] ETH    = 16'h005C;
    localparam logic [47:0] TB_MAC = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] BAD_MAC = 48'h0A0B_0C0D_0E10;
`ifdef RVVI_ACK_MAC_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] RxTdata = '0;
    logic [3:0]  RxTkeep = '0;
    logic        RxTvalid = 1'b0;
    logic        RxTlast = 1'b0;
    logic        RxTready;
    logic        SentFrame = 1'b0;
    logic        ExternalStall, AckValid;
    logic [63:0] AckFrameCount, AckMinstret;
    logic [31:0] HostLoad;
    logic [7:0]  Outstanding;
    logic [15:0] LostFrames, BadFrames;

    int total = 0;
    int bad = 0;
    int ack_seen = 0;
    logic [31:0] fw [16];

    // behavioural reference model state
    longint unsigned m_exp, m_lost;
    int              m_out, m_bad, m_acks;
    logic [63:0]     m_fc, m_mi;
    logic [31:0]     m_ld;

    rvvi_ack_receiver #(
        .MAX_OUTSTANDING(8),
        .ETH_TYPE(ETH),
        .LOCAL_MAC(TB_MAC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .RxTdata(RxTdata), .RxTkeep(RxTkeep), .RxTvalid(RxTvalid),
        .RxTlast(RxTlast), .RxTready(RxTready), .SentFrame(SentFrame),
        .ExternalStall(ExternalStall), .AckValid(AckValid),
        .AckFrameCount(AckFrameCount), .AckMinstret(AckMinstret),
        .HostLoad(HostLoad), .Outstanding(Outstanding),
        .LostFrames(LostFrames), .BadFrames(BadFrames)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (AckValid === 1'b1) ack_seen++;

    task automatic model_reset();
        m_exp = 0; m_lost = 0; m_out = 0; m_bad = 0; m_acks = 0;
        m_fc = '0; m_mi = '0; m_ld = '0;
    endtask

    task automatic do_reset();
        RxTvalid = 1'b0; RxTlast = 1'b0; SentFrame = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] et,
                               input logic [63:0] c, input logic [63:0] mi,
                               input logic [31:0] ld);
        fw[0] = dst[31:0];
        fw[1] = {16'h1234, dst[47:32]};
        fw[2] = 32'h5678_9ABC;
        fw[3] = {16'hABCD, et};
        fw[4] = c[31:0];
        fw[5] = c[63:32];
        fw[6] = mi[31:0];
        fw[7] = mi[63:32];
        fw[8] = ld;
        for (int i = 9; i < 16; i++) fw[i] = $urandom;
    endtask

    task automatic send_frame(input int first, input int nb, input int kb,
                              input bit gaps, input bit with_last);
        int w;
        for (int i = 0; i < nb; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                RxTvalid = 1'b0;
                @(negedge clk);
            end
            RxTvalid = 1'b1;
            RxTdata  = fw[first + i];
            RxTkeep  = (i == kb) ? 4'h7 : 4'hF;
            RxTlast  = with_last && (i == nb - 1);
            w = 0;
            while (RxTready !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) begin
                total++; bad++;
                $display("FAIL rx_ready_timeout: RxTready=%b required 1", RxTready);
            end
            @(negedge clk);
        end
        RxTvalid = 1'b0;
        RxTlast  = 1'b0;
    endtask

    task automatic pulse_sent(input int k);
        for (int i = 0; i < k; i++) begin
            SentFrame = 1'b1;
            @(negedge clk);
        end
        SentFrame = 1'b0;
        m_out = (m_out + k > 255) ? 255 : m_out + k;
    endtask

    task automatic model_frame(input int nb, input int kb, input logic [15:0] et,
                               input logic [47:0] dst, input logic [63:0] c,
                               input logic [63:0] mi, input logic [31:0] ld);
        longint unsigned diff;
        if (FILT_EN && dst != TB_MAC) return;
        if (nb != 9 || kb >= 0 || et != ETH) begin
            if (m_bad < 65535) m_bad++;
            return;
        end
        if (c >= m_exp) begin
            m_acks++;
            diff   = c - m_exp;
            m_lost = (m_lost + diff > 65535) ? 65535 : m_lost + diff;
            m_out  = (longint'(m_out) > diff + 1) ? m_out - int'(diff + 1) : 0;
            m_exp  = c + 1;
            m_fc   = c; m_mi = mi; m_ld = ld;
        end else if (m_bad < 65535) begin
            m_bad++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        RxTvalid = 1'b0; SentFrame = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({RxTready, ExternalStall, AckValid, AckFrameCount, AckMinstret, HostLoad,
             Outstanding, LostFrames, BadFrames} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b stall=%b ack=%b fc=%h mi=%h ld=%h out=%0d lost=%0d bad=%0d required all 0",
                     RxTready, ExternalStall, AckValid, AckFrameCount, AckMinstret,
                     HostLoad, Outstanding, LostFrames, BadFrames);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (RxTready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: RxTready=%b required 1", RxTready);
        end
        model_reset();
    endtask

    task automatic test_stall();
        do_reset();
        pulse_sent(8);
        @(negedge clk);
        total++;
        if (Outstanding !== 8'd8 || ExternalStall !== 1'b1) begin
            bad++; $display("FAIL stall_set: out=%0d stall=%b required 8/1", Outstanding, ExternalStall);
        end
        build_frame(TB_MAC, ETH, 64'd0, 64'h99, 32'd7);
        send_frame(0, 9, -1, 0, 1);
        @(negedge clk);
        total++;
        if (AckValid !== 1'b1 || Outstanding !== 8'd7 || ExternalStall !== 1'b1) begin
            bad++; $display("FAIL stall_commit: ack=%b out=%0d stall=%b required 1/7/1", AckValid, Outstanding, ExternalStall);
        end
        @(negedge clk);
        total++;
        if (ExternalStall !== 1'b0 || AckValid !== 1'b0) begin
            bad++; $display("FAIL stall_release: stall=%b ack=%b required 0/0", ExternalStall, AckValid);
        end
    endtask

    task automatic test_good_sequence();
        int base;
        do_reset();
        base = ack_seen;
        for (int i = 0; i < 3; i++) begin
            build_frame(TB_MAC, ETH, 64'(i), 64'(16 * (i + 1)), 32'd1);
            send_frame(0, 9, -1, 0, 1);
        end
        repeat (2) @(negedge clk);
        total++;
        if (ack_seen - base !== 3 || AckMinstret !== 64'h30 || HostLoad !== 32'd1 ||
            LostFrames !== 16'd0 || AckFrameCount !== 64'd2) begin
            bad++; $display("FAIL good_seq: acks=%0d mi=%h ld=%h lost=%0d fc=%0d required 3/30/1/0/2",
                            ack_seen - base, AckMinstret, HostLoad, LostFrames, AckFrameCount);
        end
    endtask

    task automatic test_lost_and_stale();
        int base;
        do_reset();
        pulse_sent(10);
        for (int i = 0; i < 3; i++) begin
            build_frame(TB_MAC, ETH, 64'(i), 64'h1, 32'h2);
            send_frame(0, 9, -1, 0, 1);
        end
        repeat (2) @(negedge clk);
        base = ack_seen;
        build_frame(TB_MAC, ETH, 64'd5, 64'h55, 32'h5);
        send_frame(0, 9, -1, 0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (LostFrames !== 16'd2 || Outstanding !== 8'd4 || ack_seen - base !== 1 || AckFrameCount !== 64'd5) begin
            bad++; $display("FAIL lost_skip: lost=%0d out=%0d acks=%0d fc=%0d required 2/4/1/5",
                            LostFrames, Outstanding, ack_seen - base, AckFrameCount);
        end
        build_frame(TB_MAC, ETH, 64'd4, 64'h44, 32'h4);
        send_frame(0, 9, -1, 0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (BadFrames !== 16'd1 || ack_seen - base !== 1 || Outstanding !== 8'd4 ||
            AckMinstret !== 64'h55 || HostLoad !== 32'h5) begin
            bad++; $display("FAIL stale_reply: bad=%0d acks=%0d out=%0d mi=%h ld=%h required 1/1/4/55/5",
                            BadFrames, ack_seen - base, Outstanding, AckMinstret, HostLoad);
        end
        build_frame(TB_MAC, ETH, 64'd6, 64'h66, 32'h6);
        send_frame(0, 9, -1, 0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (LostFrames !== 16'd2 || Outstanding !== 8'd3 || ack_seen - base !== 2) begin
            bad++; $display("FAIL expseq_after_skip: lost=%0d out=%0d acks=%0d required 2/3/2",
                            LostFrames, Outstanding, ack_seen - base);
        end
    endtask

    task automatic test_malformed();
        int base;
        do_reset();
        base = ack_seen;
        build_frame(TB_MAC, 16'h0800, 64'd0, 64'h1, 32'h1);
        send_frame(0, 9, -1, 0, 1);
        @(negedge clk);
        total++;
        if (BadFrames !== 16'd1) begin
            bad++; $display("FAIL bad_ethertype: bad=%0d required 1", BadFrames);
        end
        build_frame(TB_MAC, ETH, 64'd0, 64'h1, 32'h1);
        send_frame(0, 6, -1, 0, 1);
        @(negedge clk);
        total++;
        if (BadFrames !== 16'd2) begin
            bad++; $display("FAIL short_frame: bad=%0d required 2", BadFrames);
        end
        send_frame(0, 11, -1, 0, 1);
        @(negedge clk);
        total++;
        if (BadFrames !== 16'd3) begin
            bad++; $display("FAIL long_frame: bad=%0d required 3", BadFrames);
        end
        send_frame(0, 9, 2, 0, 1);
        @(negedge clk);
        total++;
        if (BadFrames !== 16'd4) begin
            bad++; $display("FAIL bad_keep: bad=%0d required 4", BadFrames);
        end
        build_frame(TB_MAC, ETH, 64'd0, 64'hAB, 32'hCD);
        send_frame(0, 9, -1, 0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (ack_seen - base !== 1 || BadFrames !== 16'd4 || AckMinstret !== 64'hAB) begin
            bad++; $display("FAIL good_after_drain: acks=%0d bad=%0d mi=%h required 1/4/ab",
                            ack_seen - base, BadFrames, AckMinstret);
        end
    endtask

    task automatic test_sent_in_commit();
        do_reset();
        pulse_sent(3);
        build_frame(TB_MAC, ETH, 64'd0, 64'h1, 32'h1);
        send_frame(0, 9, -1, 0, 1);
        SentFrame = 1'b1;
        @(negedge clk);
        SentFrame = 1'b0;
        total++;
        if (AckValid !== 1'b1 || Outstanding !== 8'd3) begin
            bad++; $display("FAIL sent_in_commit: ack=%b out=%0d required 1/3", AckValid, Outstanding);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        pulse_sent(260);
        @(negedge clk);
        total++;
        if (Outstanding !== 8'hFF) begin
            bad++; $display("FAIL out_saturate: out=%0d required 255", Outstanding);
        end
        build_frame(TB_MAC, ETH, 64'h1_0000_0000, 64'h7, 32'h7);
        send_frame(0, 9, -1, 0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (LostFrames !== 16'hFFFF || Outstanding !== 8'd0 || AckFrameCount !== 64'h1_0000_0000) begin
            bad++; $display("FAIL lost_saturate: lost=%h out=%0d fc=%h required ffff/0/100000000",
                            LostFrames, Outstanding, AckFrameCount);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        do_reset();
        build_frame(TB_MAC, ETH, 64'd0, 64'h3, 32'h3);
        send_frame(0, 4, -1, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        base = ack_seen;
        send_frame(4, 5, -1, 0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (BadFrames !== 16'd1 || ack_seen - base !== 0 || Outstanding !== 8'd0) begin
            bad++; $display("FAIL reset_mid_frame: bad=%0d acks=%0d out=%0d required 1/0/0",
                            BadFrames, ack_seen - base, Outstanding);
        end
    endtask

`ifdef RVVI_ACK_MAC_FILTER_EN
    task automatic test_mac_filter();
        int base;
        do_reset();
        base = ack_seen;
        build_frame(BAD_MAC, ETH, 64'd0, 64'h1, 32'h1);
        send_frame(0, 9, -1, 0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (ack_seen - base !== 0 || BadFrames !== 16'd0) begin
            bad++; $display("FAIL mac_other: acks=%0d bad=%0d required 0/0", ack_seen - base, BadFrames);
        end
        build_frame(TB_MAC, ETH, 64'd0, 64'h1, 32'h1);
        send_frame(0, 9, -1, 0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (ack_seen - base !== 1 || BadFrames !== 16'd0) begin
            bad++; $display("FAIL mac_local: acks=%0d bad=%0d required 1/0", ack_seen - base, BadFrames);
        end
    endtask
`endif

    task automatic test_random();
        int base, kind, nb, kb;
        logic [15:0] et;
        logic [47:0] dst;
        logic [63:0] c, mi;
        logic [31:0] ld;
        do_reset();
        base = ack_seen;
        for (int it = 0; it < 60; it++) begin
            pulse_sent($urandom_range(0, 3));
            kind = $urandom_range(0, 10);
            c = m_exp; et = ETH; dst = TB_MAC; nb = 9; kb = -1;
            mi = {$urandom, $urandom};
            ld = $urandom;
            case (kind)
                3: c = m_exp + 64'($urandom_range(1, 3));
                4: c = (m_exp > 0) ? m_exp - 1 : m_exp;
                5: et = 16'h0800;
                6: nb = $urandom_range(1, 8);
                7: nb = $urandom_range(10, 12);
                8: kb = $urandom_range(0, 8);
                9: dst = BAD_MAC;
                10: c = m_exp + 64'h1_0000_0000;
                default: c = m_exp;
            endcase
            build_frame(dst, et, c, mi, ld);
            send_frame(0, nb, kb, 1, 1);
            model_frame(nb, kb, et, dst, c, mi, ld);
            repeat (2) @(negedge clk);
            total++;
            if (ack_seen - base !== m_acks) begin
                bad++; $display("FAIL rnd_acks it=%0d: got %0d required %0d", it, ack_seen - base, m_acks);
            end
            total++;
            if (AckFrameCount !== m_fc || AckMinstret !== m_mi || HostLoad !== m_ld) begin
                bad++; $display("FAIL rnd_fields it=%0d: fc=%h mi=%h ld=%h required %h/%h/%h",
                                it, AckFrameCount, AckMinstret, HostLoad, m_fc, m_mi, m_ld);
            end
            total++;
            if (Outstanding !== 8'(m_out) || ExternalStall !== (m_out >= 8)) begin
                bad++; $display("FAIL rnd_outstanding it=%0d: out=%0d stall=%b required %0d/%b",
                                it, Outstanding, ExternalStall, m_out, m_out >= 8);
            end
            total++;
            if (LostFrames !== 16'(m_lost) || BadFrames !== 16'(m_bad)) begin
                bad++; $display("FAIL rnd_counters it=%0d: lost=%0d bad=%0d required %0d/%0d",
                                it, LostFrames, BadFrames, m_lost, m_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_good_sequence();
        test_lost_and_stale();
        test_malformed();
        test_sent_in_commit();
        test_saturation();
        test_reset_mid_frame();
`ifdef RVVI_ACK_MAC_FILTER_EN
        test_mac_filter();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvvi_ack_receiver.md
Name: rvvi_ack_receiver

Overview:
Hardware-side consumer of the short acknowledgement frames that the host returns for each RVVI trace frame. It sits after the Ethernet MAC RX AXI-stream, next to hwrvvitracer. It parses the 9-word reply and extracts the echoed frame count, Minstret and the 32-bit host-load word. It tracks outstanding unacknowledged trace frames, counts lost and bad replies, and asserts ExternalStall when the host falls too far behind.

Parameters:
MAX_OUTSTANDING, 8, stall threshold for unacknowledged trace frames (1..255)
ETH_TYPE, 16'h005C, required value of word3[15:0]
LOCAL_MAC, 48'h0000_0000_0000, destination MAC accepted; used only with RVVI_ACK_MAC_FILTER_EN

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
RxTdata  in  32  AXI-stream RX data (byte 0 in [7:0])
RxTkeep  in  4  AXI-stream byte enables
RxTvalid  in  1  RX beat valid
RxTlast  in  1  last beat of frame
RxTready  out  1  RX ready
SentFrame  in  1  one-cycle pulse per trace frame emitted by the tracer
ExternalStall  out  1  high while Outstanding >= MAX_OUTSTANDING
AckValid  out  1  one-cycle pulse when a good reply commits
AckFrameCount  out  64  frame count of last good reply
AckMinstret  out  64  Minstret of last good reply
HostLoad  out  32  host-load word of last good reply
Outstanding  out  8  unacknowledged frame count
LostFrames  out  16  saturating count of skipped sequence numbers
BadFrames  out  16  saturating count of malformed or stale replies

Behaviour:
- Reset values: all outputs 0. RxTready is 1 from the first cycle after reset release. Internal ExpSeq is 0.
- RxTready is 1 in every state except COMMIT. A beat is accepted on RxTvalid & RxTready.
- Frame layout (word index = beat number):
  - w0: dst MAC[31:0]
  - w1: dst MAC[47:32] / src MAC[15:0]
  - w2: src MAC[47:16]
  - w3: [15:0] ethertype
  - w4/w5: frame count lo/hi
  - w6/w7: Minstret lo/hi
  - w8: host load
- States and transitions:
  - IDLE: first accepted beat -> RECV, with beat counter = 1.
  - RECV: capture words; on each beat check RxTkeep == 4'hF, and check w3[15:0] == ETH_TYPE on w3.
    - RxTlast on beat 8 with no error -> COMMIT.
    - RxTlast before beat 8, or any error -> frame marked bad; when RxTlast arrives -> IDLE, BadFrames += 1.
    - Beat 8 without RxTlast -> DRAIN.
  - DRAIN: discard beats until RxTlast, then -> IDLE, BadFrames += 1.
  - COMMIT: one cycle, RxTready = 0; sequence check on count C, then -> IDLE.
    - C == ExpSeq: AckValid pulse; outputs updated; Outstanding -= 1.
    - C > ExpSeq: AckValid pulse; LostFrames += (C - ExpSeq), saturating at 16'hFFFF; Outstanding -= (C - ExpSeq + 1).
    - C < ExpSeq (stale/duplicate): BadFrames += 1; no AckValid; outputs, Outstanding and ExpSeq unchanged.
    - On accept, ExpSeq <= C + 1 (64-bit wrap allowed).
- Outstanding arithmetic:
  - Decrement floors at 0.
  - SentFrame increments, saturating at 8'hFF.
  - SentFrame in the same cycle as a COMMIT decrement: both applied, as Outstanding + 1 - dec, floored at 0.
- ExternalStall is registered: it reflects Outstanding one cycle later, so it deasserts the cycle after a commit takes Outstanding below the threshold.
- Counters never wrap; they hold at all-ones.
- Reset asserted mid-frame: the frame is dropped and all state returns to reset values. The remaining beats of that frame are treated as a new frame and end up counted as bad.

Optional Feature:
RVVI_ACK_MAC_FILTER_EN
- Defined: the dst MAC from w0/w1 must equal LOCAL_MAC. On mismatch the frame is silently discarded: it goes to DRAIN/IDLE with no BadFrames increment and no sequence check.
- Undefined: the MAC is ignored and LOCAL_MAC is unused.

Test Plan:
1. 8 SentFrame pulses, no replies -> Outstanding = 8, ExternalStall = 1. Then a good reply with C = 0 -> AckValid; Outstanding = 7; ExternalStall = 0 one cycle later.
2. Good replies C = 0, 1, 2 with Minstret 0x10/0x20/0x30 and load 1 -> three AckValid pulses; AckMinstret = 0x30, HostLoad = 1, LostFrames = 0.
3. After C = 2, a reply with C = 5 -> LostFrames = 2, Outstanding reduced by 3, ExpSeq = 6. Then a reply with C = 4 -> BadFrames = 1, no AckValid.
4. Reply with w3[15:0] = 16'h0800 -> BadFrames += 1. Reply with RxTlast on beat 5 -> BadFrames += 1. Reply with 11 beats -> DRAIN, BadFrames += 1, and the next good frame is accepted.
5. SentFrame asserted in the COMMIT cycle of C == ExpSeq with Outstanding = 3 -> Outstanding stays 3.
6. With RVVI_ACK_MAC_FILTER_EN defined and LOCAL_MAC = 48'h0A0B0C0D0E0F: frame to another MAC -> no AckValid, BadFrames unchanged. Frame to LOCAL_MAC -> AckValid.
